// File: rtl/pc_fetch_unit_pkg.sv
// Shared encodings for the instruction-fetch unit: FSM states, fault causes
// and the reset value of the instruction register.
package pc_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_REQ   = 2'b00,
    FETCH_WAIT  = 2'b01,
    FETCH_HOLD  = 2'b10,
    FETCH_FAULT = 2'b11
  } fetch_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_MISALIGNED = 2'b01,
    CAUSE_BUS_ERR    = 2'b10,
    CAUSE_TIMEOUT    = 2'b11
  } fault_cause_e;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_fetch_unit.sv
// Non-pipelined instruction fetch: owns the architectural PC, issues one
// imem read per PC and holds the returned word for decode until retire.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] next_pc,
  input  logic        pc_update,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  // The counter holds the number of completed WAIT cycles, so the last
  // permitted WAIT cycle is the one where it reads TIMEOUT_CYCLES-1.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  fetch_state_e state_q, state_d;
  fault_cause_e cause_q, cause_d;
  logic [31:0]  pc_q;
  logic [31:0]  instr_q;
  logic [7:0]   wait_cnt_q;
  logic         pc_load;
  logic         instr_load;
  logic         cnt_clear;

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case statement can leave one unassigned and infer a latch.
    state_d    = state_q;
    cause_d    = cause_q;
    pc_load    = 1'b0;
    instr_load = 1'b0;
    cnt_clear  = 1'b0;

    case (state_q)
      FETCH_REQ: begin
        if (imem_req_ready) begin
          state_d   = FETCH_WAIT;
          cnt_clear = 1'b1;
        end
      end

      FETCH_WAIT: begin
        // A response arriving in the expiry cycle takes priority over the timeout.
        if (imem_resp_valid) begin
          if (imem_resp_err) begin
            state_d = FETCH_FAULT;
            cause_d = CAUSE_BUS_ERR;
          end else begin
            state_d    = FETCH_HOLD;
            instr_load = 1'b1;
          end
        end else if (wait_cnt_q == LAST_WAIT) begin
          state_d = FETCH_FAULT;
          cause_d = CAUSE_TIMEOUT;
        end
      end

      FETCH_HOLD: begin
        if (pc_update) begin
          if (next_pc[1:0] != 2'b00) begin
            state_d = FETCH_FAULT;
            cause_d = CAUSE_MISALIGNED;
          end else if (next_pc != pc_q) begin
            state_d = FETCH_REQ;
            pc_load = 1'b1;
          end
          // next_pc == pc is a stall replay: keep the held word, no refetch.
        end
      end

      FETCH_FAULT: ;  // sticky until reset

      default: state_d = FETCH_FAULT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FETCH_REQ;
      cause_q    <= CAUSE_NONE;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (pc_load)    pc_q    <= next_pc;
      if (instr_load) instr_q <= imem_resp_data;
      if (cnt_clear) begin
        wait_cnt_q <= 8'd0;
      end else if (state_q == FETCH_WAIT) begin
        wait_cnt_q <= wait_cnt_q + 8'd1;
      end
    end
  end

  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign imem_req_valid = (state_q == FETCH_REQ);
  assign instr_valid    = (state_q == FETCH_HOLD);
  assign instr          = instr_q;
  assign fault          = (state_q == FETCH_FAULT);
  assign fault_cause    = cause_q;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Instruction-fetch end of the next-PC path. It owns the architectural PC register and loads it from sel_next_pc's next_pc when the core retires an instruction. It issues one instruction-memory read per PC over a valid/ready request channel and presents the returned word to decode with instr_valid. The block is non-pipelined: at most one outstanding fetch. Misaligned targets, bus errors and response timeouts put it into a sticky fault state.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; first fetch address.
TIMEOUT_CYCLES, 255, maximum cycles spent in WAIT before a timeout fault. Range 1..255; 8-bit counter.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
next_pc  in  32  next PC from sel_next_pc
pc_update  in  1  retire strobe; load next_pc into PC (effective only in HOLD)
pc  out  32  current PC, to sel_next_pc and the branch adder
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  32  fetch address; always equals pc
imem_resp_valid  in  1  read data valid
imem_resp_data  in  32  read data
imem_resp_err  in  1  bus error; qualified by imem_resp_valid
instr_valid  out  1  instr holds the word fetched from pc
instr  out  32  fetched instruction
fault  out  1  sticky fault flag
fault_cause  out  2  2'b00 none, 2'b01 misaligned, 2'b10 bus error, 2'b11 timeout

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc=RESET_PC, instr=32'h0000_0013 (NOP), instr_valid=0.
  - fault=0, fault_cause=0, timeout counter=0.
  - state=REQ, so imem_req_valid=1 in the first cycle after release.
- States: REQ, WAIT, HOLD, FAULT. The state register is the only control state.
- REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready=1, go to WAIT and clear the counter.
  - Otherwise stay in REQ, holding addr and valid stable.
- WAIT:
  - imem_req_valid=0; the counter increments every cycle.
  - imem_resp_valid=1 with err=0: latch instr, go to HOLD. instr_valid=1 from the next cycle.
  - imem_resp_valid=1 with err=1: go to FAULT, cause=2'b10. instr is unchanged.
  - Counter reaches TIMEOUT_CYCLES with no response: go to FAULT, cause=2'b11.
  - A response in the same cycle the counter expires wins; no fault is raised.
- HOLD:
  - instr_valid=1 and instr stable until pc_update.
  - On pc_update:
    - next_pc[1:0]!=0: pc is not updated; go to FAULT, cause=2'b01. instr_valid drops next cycle.
    - next_pc==pc (I2/S2 stall replay): stay in HOLD with the same instr and no refetch. instr_valid stays 1.
    - Otherwise: pc<=next_pc, instr_valid<=0, go to REQ. imem_req_valid is 1 in the cycle after the strobe.
- FAULT:
  - fault=1; fault_cause holds its value; instr_valid=0; imem_req_valid=0.
  - All inputs are ignored. Only reset exits FAULT.
- pc_update outside HOLD is ignored. Decode must not strobe it without instr_valid.
- imem_resp_valid outside WAIT is ignored. Such a response is stale and must not update instr or state.
- Latency: strobe at cycle t gives req at t+1. With ready=1 and a one-cycle memory, the response arrives at t+2 and instr_valid=1 at t+3. Best case is 3 cycles per instruction.
- Reset asserted mid-WAIT: state returns to REQ. A late response after reset release arrives while in REQ and is ignored.
- Widths: the PC is 32 bits with no wrap check. pc=32'hFFFF_FFFC followed by next_pc=32'h0 is a legal fetch.

Decomposition:
- Add to defines.v:
  - the state encodings FETCH_REQ/FETCH_WAIT/FETCH_HOLD/FETCH_FAULT;
  - the fault-cause codes;
  - the NOP constant 32'h0000_0013.
- Everything stays in one module; no sub-module is needed. The timeout counter is an inline 8-bit register.

Test Plan:
- Reset release, ready=1, memory returns 32'h00500093 one cycle later -> imem_addr=0 at cycle 1; instr_valid=1, instr=32'h00500093 at cycle 3; fault=0.
- In HOLD, pc=0x10, pc_update with next_pc=0x40 -> pc=0x40 next cycle; instr_valid=0; imem_req_valid=1, addr=0x40.
- In HOLD, pc=0x20, pc_update with next_pc=0x20 for 3 cycles -> no request issued; instr_valid stays 1; instr unchanged.
- pc_update with next_pc=0x42 -> fault=1, cause=2'b01, pc stays at the old value; later pc_update and responses have no effect until rst_n=0.
- imem_req_ready held 0 for 5 cycles -> addr and valid stable for all 5; then ready=1, response with err=1 -> fault=1, cause=2'b10.
- TIMEOUT_CYCLES=4, no response -> cause=2'b11 after 4 WAIT cycles. A response injected in the 4th WAIT cycle -> HOLD with no fault. A stray resp_valid during REQ is ignored.
